// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path.
// Widths default the arbiter and its interface; rrNext wraps the round-robin pointer.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  function automatic int rrNext(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-source / register-file bundle for regfile_write_arbiter.
// Read-bypass signals exist only when RF_ARB_FWD_EN is defined.
interface regfile_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic                      ctrl_writeEnable;
  logic [ADDR_W-1:0]         ctrl_writeReg;
  logic [DATA_W-1:0]         data_writeReg;
`ifdef RF_ARB_FWD_EN
  logic [ADDR_W-1:0]         ctrl_readRegA;
  logic [ADDR_W-1:0]         ctrl_readRegB;
  logic [DATA_W-1:0]         rf_readRegA;
  logic [DATA_W-1:0]         rf_readRegB;
  logic [DATA_W-1:0]         data_readRegA;
  logic [DATA_W-1:0]         data_readRegB;

  modport master (
    output req_valid, req_reg, req_data, flush,
    output ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
    input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  req_valid, req_reg, req_data, flush,
    input  ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
    output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output data_readRegA, data_readRegB
  );
`else
  modport master (
    output req_valid, req_reg, req_data, flush,
    input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  req_valid, req_reg, req_data, flush,
    output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
// Produces a one-hot grant, its index, and whether anything was granted.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grantIdx,
  output logic               anyGrant
);

  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] cand;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    cand     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // Candidate index = (ptr + off) mod NUM_REQ, with one extra bit so the wrap is exact.
      cand = {1'b0, ptr} + SUM_W'(off);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!anyGrant && req[cand[PTR_W-1:0]]) begin
        anyGrant                 = 1'b1;
        grant[cand[PTR_W-1:0]]   = 1'b1;
        grantIdx                 = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port; granted write appears one cycle later, writes to r0 are dropped.
// RF_ARB_FWD_EN adds a combinational read bypass of the staged write; default build has no bypass ports.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   grantIdx;
  logic [NUM_REQ-1:0] arbReq;
  logic [NUM_REQ-1:0] grant;
  logic               anyGrant;
  logic [ADDR_W-1:0]  grantReg;
  logic [DATA_W-1:0]  grantData;
  rf_wr_t             stage;

  // Reset and flush both suppress grants; nothing may transfer in those cycles.
  assign arbReq = (reset || bus.flush) ? '0 : bus.req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req      (arbReq),
    .ptr      (rrPtr),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    grantReg  = '0;
    grantData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantReg  = bus.req_reg[i*ADDR_W +: ADDR_W];
        grantData = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Address/data are held when nothing transfers so the regfile inputs stay quiet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr <= '0;
      stage <= '0;
    end else begin
      stage.en <= anyGrant && (grantReg != RF_ZERO_REG);
      if (anyGrant) begin
        stage.addr <= grantReg;
        stage.data <= grantData;
        rrPtr      <= PTR_W'(rrNext(int'(grantIdx), NUM_REQ));
      end
    end
  end

  assign bus.ctrl_writeEnable = stage.en;
  assign bus.ctrl_writeReg    = stage.addr;
  assign bus.data_writeReg    = stage.data;

`ifdef RF_ARB_FWD_EN
  // stage.en is never set for r0, but the explicit check keeps r0 reads hard-wired.
  assign bus.data_readRegA = (stage.en && stage.addr == bus.ctrl_readRegA &&
                              bus.ctrl_readRegA != RF_ZERO_REG) ? stage.data : bus.rf_readRegA;
  assign bus.data_readRegB = (stage.en && stage.addr == bus.ctrl_readRegB &&
                              bus.ctrl_readRegB != RF_ZERO_REG) ? stage.data : bus.rf_readRegB;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, round-robin order, r0 drop, flush, async reset, back-to-back, bypass.
module tb_regfile_write_arbiter;
  import rf_pkg::*;

  localparam int N = 3;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) bif ();

  regfile_write_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (RF_DATA_W),
    .ADDR_W  (RF_ADDR_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setSrc(input int i, input logic [4:0] r, input logic [31:0] d);
    bif.req_reg[i*5 +: 5]   = r;
    bif.req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.req_valid = 3'b111;
    tick();
    tick();
    checks++; if (bif.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", bif.req_ready); end
    checks++; if (bif.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bif.ctrl_writeEnable); end
    checks++; if (bif.ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL reset_reg: got %0d want 0", bif.ctrl_writeReg); end
    checks++; if (bif.data_writeReg !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bif.data_writeReg); end
    bif.req_valid = 3'b000;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bif.req_ready !== 3'b000) begin errors++; $display("FAIL idle_ready[%0d]: got %b want 000", k, bif.req_ready); end
      tick();
      checks++; if (bif.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL idle_en[%0d]: got %b want 0", k, bif.ctrl_writeEnable); end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] expG;
    int s;
    for (int i = 0; i < N; i++) setSrc(i, 5'(i + 1), 32'h100 + i);
    bif.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      s = k % 3;
      expG = 3'b001 << s;
      #1;
      checks++; if (bif.req_ready !== expG) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bif.req_ready, expG); end
      tick();
      checks++; if (bif.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL rr_en[%0d]: got %b want 1", k, bif.ctrl_writeEnable); end
      checks++; if (bif.ctrl_writeReg !== 5'(s + 1)) begin errors++; $display("FAIL rr_reg[%0d]: got %0d want %0d", k, bif.ctrl_writeReg, s + 1); end
      checks++; if (bif.data_writeReg !== 32'h100 + s) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, bif.data_writeReg, 32'h100 + s); end
    end
    bif.req_valid = 3'b000;
    tick();
    checks++; if (bif.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL rr_idle_en: got %b want 0", bif.ctrl_writeEnable); end
    checks++; if (bif.ctrl_writeReg !== 5'd3) begin errors++; $display("FAIL rr_hold_reg: got %0d want 3", bif.ctrl_writeReg); end
    checks++; if (bif.data_writeReg !== 32'h102) begin errors++; $display("FAIL rr_hold_data: got %h want 102", bif.data_writeReg); end
  endtask

  task automatic test_zero_reg();
    setSrc(1, 5'd0, 32'hDEAD);
    bif.req_valid = 3'b010;
    #1;
    checks++; if (bif.req_ready !== 3'b010) begin errors++; $display("FAIL zero_ready: got %b want 010", bif.req_ready); end
    tick();
    checks++; if (bif.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL zero_en: got %b want 0", bif.ctrl_writeEnable); end
    bif.req_valid = 3'b111;
    #1;
    checks++; if (bif.req_ready !== 3'b100) begin errors++; $display("FAIL zero_ptr: got %b want 100", bif.req_ready); end
    bif.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_flush();
    setSrc(2, 5'd5, 32'h1234);
    bif.req_valid = 3'b100;
    #1;
    checks++; if (bif.req_ready !== 3'b100) begin errors++; $display("FAIL flush_pre_ready: got %b want 100", bif.req_ready); end
    tick();
    checks++; if (bif.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL flush_pre_en: got %b want 1", bif.ctrl_writeEnable); end
    checks++; if (bif.ctrl_writeReg !== 5'd5) begin errors++; $display("FAIL flush_pre_reg: got %0d want 5", bif.ctrl_writeReg); end
    setSrc(2, 5'd6, 32'h5678);
    bif.flush = 1'b1;
    #1;
    checks++; if (bif.req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b want 000", bif.req_ready); end
    tick();
    checks++; if (bif.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL flush_en: got %b want 0", bif.ctrl_writeEnable); end
    checks++; if (bif.ctrl_writeReg !== 5'd5) begin errors++; $display("FAIL flush_hold_reg: got %0d want 5", bif.ctrl_writeReg); end
    checks++; if (bif.data_writeReg !== 32'h1234) begin errors++; $display("FAIL flush_hold_data: got %h want 1234", bif.data_writeReg); end
    bif.flush = 1'b0;
    bif.req_valid = 3'b111;
    #1;
    checks++; if (bif.req_ready !== 3'b001) begin errors++; $display("FAIL flush_ptr: got %b want 001", bif.req_ready); end
    bif.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    setSrc(1, 5'd9, 32'hABCD);
    bif.req_valid = 3'b010;
    #1;
    checks++; if (bif.req_ready !== 3'b010) begin errors++; $display("FAIL mid_ready: got %b want 010", bif.req_ready); end
    tick();
    checks++; if (bif.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL mid_staged_en: got %b want 1", bif.ctrl_writeEnable); end
    reset = 1'b1;
    #1;
    checks++; if (bif.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL mid_async_en: got %b want 0", bif.ctrl_writeEnable); end
    checks++; if (bif.ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL mid_async_reg: got %0d want 0", bif.ctrl_writeReg); end
    checks++; if (bif.req_ready !== 3'b000) begin errors++; $display("FAIL mid_ready_in_reset: got %b want 000", bif.req_ready); end
    bif.req_valid = 3'b111;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bif.req_ready !== 3'b001) begin errors++; $display("FAIL mid_ptr: got %b want 001", bif.req_ready); end
    bif.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back();
    setSrc(0, 5'd10, 32'hA0);
    setSrc(1, 5'd11, 32'hB1);
    bif.req_valid = 3'b011;
    #1;
    checks++; if (bif.req_ready !== 3'b001) begin errors++; $display("FAIL b2b_g0: got %b want 001", bif.req_ready); end
    tick();
    checks++; if (bif.ctrl_writeReg !== 5'd10 || bif.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL b2b_w0: got en=%b reg=%0d want en=1 reg=10", bif.ctrl_writeEnable, bif.ctrl_writeReg); end
    #1;
    checks++; if (bif.req_ready !== 3'b010) begin errors++; $display("FAIL b2b_g1: got %b want 010", bif.req_ready); end
    tick();
    checks++; if (bif.data_writeReg !== 32'hB1 || bif.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL b2b_w1: got en=%b data=%h want en=1 data=b1", bif.ctrl_writeEnable, bif.data_writeReg); end
    bif.req_valid = 3'b001;
    #1;
    checks++; if (bif.req_ready !== 3'b001) begin errors++; $display("FAIL b2b_g2: got %b want 001", bif.req_ready); end
    tick();
    checks++; if (bif.ctrl_writeReg !== 5'd10 || bif.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL b2b_w2: got en=%b reg=%0d want en=1 reg=10", bif.ctrl_writeEnable, bif.ctrl_writeReg); end
    bif.req_valid = 3'b000;
  endtask

`ifdef RF_ARB_FWD_EN
  task automatic test_forward();
    setSrc(0, 5'd7, 32'hCAFE);
    bif.req_valid = 3'b001;
    tick();
    bif.req_valid = 3'b000;
    bif.ctrl_readRegA = 5'd7;
    bif.rf_readRegA   = 32'h0;
    bif.ctrl_readRegB = 5'd3;
    bif.rf_readRegB   = 32'h1111;
    #1;
    checks++; if (bif.data_readRegA !== 32'hCAFE) begin errors++; $display("FAIL fwd_hit: got %h want cafe", bif.data_readRegA); end
    checks++; if (bif.data_readRegB !== 32'h1111) begin errors++; $display("FAIL fwd_miss: got %h want 1111", bif.data_readRegB); end
    bif.ctrl_readRegA = 5'd0;
    bif.rf_readRegA   = 32'h5555;
    #1;
    checks++; if (bif.data_readRegA !== 32'h5555) begin errors++; $display("FAIL fwd_r0: got %h want 5555", bif.data_readRegA); end
    tick();
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bif.req_valid = '0;
    bif.req_reg   = '0;
    bif.req_data  = '0;
    bif.flush     = 1'b0;
`ifdef RF_ARB_FWD_EN
    bif.ctrl_readRegA = '0;
    bif.ctrl_readRegB = '0;
    bif.rf_readRegA   = '0;
    bif.rf_readRegB   = '0;
`endif
    test_reset();
    test_round_robin();
    test_zero_reg();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef RF_ARB_FWD_EN
    test_forward();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
